// File: rtl/acc_sequencer.sv
// acc_sequencer: fetch/execute sequencer for a tiny accumulator machine.
// It fetches 8-bit instructions from a 16-entry instruction memory over a
// req/ack handshake and executes each in a single cycle. The arithmetic
// itself is done by an external combinational ALU. The sequencer owns acc,
// pc, the instruction register and the retired-instruction counter.
module acc_sequencer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   output logic       imem_req,
   output logic [3:0] imem_addr,
   input  logic       imem_ack,
   input  logic [7:0] imem_data,
   output logic [3:0] alu_opcode,
   output logic [3:0] alu_operand,
   output logic [7:0] alu_acc,
   input  logic [7:0] alu_result,
   output logic [7:0] acc,
   output logic [3:0] pc,
   output logic       busy,
   output logic       halted,
   output logic [7:0] retired
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_EXEC   = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   localparam logic [3:0] OP_JMP  = 4'h4;
   localparam logic [3:0] OP_HALT = 4'hF;

   state_t     state_r;
   logic [7:0] acc_r;
   logic [7:0] ir_r;
   logic [7:0] retired_r;
   logic [3:0] pc_r;
   logic       imem_req_r;
   logic       busy_r;
   logic       halted_r;

   logic       run_prev_r;
   logic       run_armed_r;
   logic       run_rise_s;
   logic [3:0] pc_inc_s;

   // A run edge only counts once run has been seen low after reset, so a
   // run level held across reset release cannot start the machine.
   assign run_rise_s = run & ~run_prev_r & run_armed_r;
   assign pc_inc_s   = pc_r + 4'd1;

   assign imem_req    = imem_req_r;
   assign imem_addr   = pc_r;
   assign alu_opcode  = ir_r[7:4];
   assign alu_operand = ir_r[3:0];
   assign alu_acc     = acc_r;
   assign acc         = acc_r;
   assign pc          = pc_r;
   assign busy        = busy_r;
   assign halted      = halted_r;
   assign retired     = retired_r;

   // Run edge history: previous-cycle run level plus the "seen low" arm flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_prev_r  <= 1'b0;
         run_armed_r <= 1'b0;
      end else begin
         run_prev_r  <= run;
         run_armed_r <= run_armed_r | ~run;
      end
   end

   // Main sequencer FSM; status outputs are registered alongside the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         acc_r      <= 8'h00;
         pc_r       <= 4'h0;
         ir_r       <= 8'h00;
         retired_r  <= 8'h00;
         imem_req_r <= 1'b0;
         busy_r     <= 1'b0;
         halted_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (run_rise_s) begin
                  state_r    <= ST_FETCH;
                  imem_req_r <= 1'b1;
                  busy_r     <= 1'b1;
               end
            end
            ST_FETCH: begin
               // pc is untouched here, so the fetch address stays stable
               // for as long as the memory keeps us waiting.
               if (imem_ack) begin
                  ir_r       <= imem_data;
                  state_r    <= ST_EXEC;
                  imem_req_r <= 1'b0;
               end
            end
            ST_EXEC: begin
               retired_r <= retired_r + 8'd1;
               case (ir_r[7:4])
                  4'h0, 4'h1, 4'h2, 4'h3: begin
                     acc_r      <= alu_result;
                     pc_r       <= pc_inc_s;
                     state_r    <= ST_FETCH;
                     imem_req_r <= 1'b1;
                  end
                  OP_JMP: begin
                     pc_r       <= ir_r[3:0];
                     state_r    <= ST_FETCH;
                     imem_req_r <= 1'b1;
                  end
                  OP_HALT: begin
                     pc_r     <= pc_inc_s;
                     state_r  <= ST_HALTED;
                     busy_r   <= 1'b0;
                     halted_r <= 1'b1;
                  end
                  default: begin
                     pc_r       <= pc_inc_s;
                     state_r    <= ST_FETCH;
                     imem_req_r <= 1'b1;
                  end
               endcase
            end
            ST_HALTED: begin
               if (run_rise_s) begin
                  state_r    <= ST_FETCH;
                  imem_req_r <= 1'b1;
                  busy_r     <= 1'b1;
                  halted_r   <= 1'b0;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               imem_req_r <= 1'b0;
               busy_r     <= 1'b0;
               halted_r   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_acc_sequencer.sv
// Self-checking bench for acc_sequencer: memory responder + reference model
// push expected post-instruction state, a monitor pops and compares it.
module tb_acc_sequencer;

   logic       clk;
   logic       rst_n;
   logic       run;
   logic       imem_req;
   logic [3:0] imem_addr;
   logic       imem_ack;
   logic [7:0] imem_data;
   logic [3:0] alu_opcode;
   logic [3:0] alu_operand;
   logic [7:0] alu_acc;
   logic [7:0] alu_result;
   logic [7:0] acc;
   logic [3:0] pc;
   logic       busy;
   logic       halted;
   logic [7:0] retired;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [3:0] pc;
      logic [7:0] acc;
      logic [7:0] ret;
      logic       hlt;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] mem [16];
   int         ack_delay = 0;
   bit         ack_noise = 0;
   int         wcnt = 0;
   bit         chk_pending = 0;
   logic [3:0] m_pc  = 4'h0;
   logic [7:0] m_acc = 8'h00;
   logic [7:0] m_ret = 8'h00;

   acc_sequencer dut (
      .clk(clk), .rst_n(rst_n), .run(run),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
      .alu_opcode(alu_opcode), .alu_operand(alu_operand), .alu_acc(alu_acc), .alu_result(alu_result),
      .acc(acc), .pc(pc), .busy(busy), .halted(halted), .retired(retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External ALU; non-ALU opcodes produce junk so a stray acc write shows.
   function automatic logic [7:0] alu_model(input logic [3:0] op, input logic [3:0] opnd, input logic [7:0] a);
      case (op)
         4'h0:    return a + {4'h0, opnd};
         4'h1:    return a - {4'h0, opnd};
         4'h2:    return a & {4'h0, opnd};
         4'h3:    return a | {4'h0, opnd};
         default: return 8'hA5;
      endcase
   endfunction

   always_comb alu_result = alu_model(alu_opcode, alu_operand, alu_acc);

   // Memory responder and reference model: acks after ack_delay wait cycles.
   always @(negedge clk) begin
      logic [7:0] instr;
      logic       hlt;
      if (rst_n && imem_req) begin
         total++;
         if (imem_addr !== m_pc) begin
            bad++;
            $display("FAIL fetch_addr got=%0h exp=%0h t=%0t", imem_addr, m_pc, $time);
         end
         total++;
         if (acc !== m_acc) begin
            bad++;
            $display("FAIL acc_during_fetch got=%0h exp=%0h t=%0t", acc, m_acc, $time);
         end
         if (wcnt >= ack_delay) begin
            instr     = mem[m_pc];
            imem_ack  = 1'b1;
            imem_data = instr;
            hlt       = 1'b0;
            m_ret     = m_ret + 8'd1;
            if (instr[7:4] <= 4'h3) begin
               m_acc = alu_model(instr[7:4], instr[3:0], m_acc);
               m_pc  = m_pc + 4'd1;
            end else if (instr[7:4] == 4'h4) begin
               m_pc = instr[3:0];
            end else if (instr[7:4] == 4'hF) begin
               m_pc = m_pc + 4'd1;
               hlt  = 1'b1;
            end else begin
               m_pc = m_pc + 4'd1;
            end
            exp_q.push_back('{m_pc, m_acc, m_ret, hlt});
            wcnt = 0;
         end else begin
            imem_ack  = 1'b0;
            imem_data = 8'hEE;
            wcnt++;
         end
      end else begin
         imem_ack  = ack_noise;
         imem_data = 8'h3F;
         wcnt      = 0;
      end
   end

   // Monitor: one cycle after each EXEC, compare architectural state.
   always @(negedge clk) begin
      exp_t e;
      if (chk_pending) begin
         chk_pending = 0;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_underflow t=%0t", $time);
         end else begin
            e = exp_q.pop_front();
            if ({pc, acc, retired, halted} !== e) begin
               bad++;
               $display("FAIL sb_exec got pc=%0h acc=%0h ret=%0h hlt=%0b exp pc=%0h acc=%0h ret=%0h hlt=%0b t=%0t",
                        pc, acc, retired, halted, e.pc, e.acc, e.ret, e.hlt, $time);
            end
         end
      end
      if (rst_n && busy && !imem_req) chk_pending = 1;
   end

   task automatic assert_reset();
      @(posedge clk); #2;
      rst_n = 1'b0;
      exp_q.delete();
      chk_pending = 0;
      m_pc  = 4'h0;
      m_acc = 8'h00;
      m_ret = 8'h00;
   endtask

   task automatic release_reset();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic apply_reset();
      assert_reset();
      release_reset();
   endtask

   task automatic pulse_run();
      @(posedge clk); #2 run = 1'b1;
      @(posedge clk); #2 run = 1'b0;
   endtask

   task automatic run_until_halted(input int budget, output int busy_cyc, output bit ok);
      busy_cyc = 0;
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (busy) busy_cyc++;
         if (halted) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic wait_retired(input logic [7:0] target, input int budget, output int cyc, output bit ok);
      cyc = 0;
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         cyc++;
         if (retired == target) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      total++;
      if ({imem_req, busy, halted, acc, pc, retired, imem_addr} !== 27'd0) begin
         bad++;
         $display("FAIL reset_state got req=%0b busy=%0b hlt=%0b acc=%0h pc=%0h ret=%0h", imem_req, busy, halted, acc, pc, retired);
      end
      release_reset();
      repeat (4) @(posedge clk);
      #2;
      total++;
      if (imem_req !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL idle_no_run got req=%0b busy=%0b exp 0 0", imem_req, busy);
      end
   endtask

   task automatic test_basic_program();
      int  cyc;
      bit  ok;
      apply_reset();
      foreach (mem[i]) mem[i] = 8'h00;
      mem[0] = 8'h05; mem[1] = 8'h12; mem[2] = 8'hF0;
      ack_delay = 0;
      pulse_run();
      run_until_halted(100, cyc, ok);
      @(negedge clk);
      total++;
      if (!ok || cyc != 6 || acc !== 8'h03 || pc !== 4'h3 || retired !== 8'h03 || halted !== 1'b1) begin
         bad++;
         $display("FAIL basic_prog got ok=%0b cyc=%0d acc=%0h pc=%0h ret=%0h exp cyc=6 acc=03 pc=3 ret=03", ok, cyc, acc, pc, retired);
      end
   endtask

   task automatic test_ack_delay();
      int  cyc;
      bit  ok;
      apply_reset();
      ack_delay = 3;
      ack_noise = 1;
      pulse_run();
      run_until_halted(200, cyc, ok);
      @(negedge clk);
      total++;
      if (!ok || cyc != 15 || acc !== 8'h03 || pc !== 4'h3 || retired !== 8'h03) begin
         bad++;
         $display("FAIL ack_delay got ok=%0b cyc=%0d acc=%0h pc=%0h ret=%0h exp cyc=15 acc=03 pc=3 ret=03", ok, cyc, acc, pc, retired);
      end
      ack_noise = 0;
      ack_delay = 0;
   endtask

   task automatic test_acc_wrap_jmp();
      int  cyc;
      bit  ok;
      apply_reset();
      foreach (mem[i]) mem[i] = 8'h00;
      mem[0] = 8'h12; mem[1] = 8'hF0; mem[2] = 8'h40;
      pulse_run();
      run_until_halted(100, cyc, ok);
      total++;
      if (!ok || acc !== 8'hFE || pc !== 4'h2) begin
         bad++;
         $display("FAIL preload got ok=%0b acc=%0h pc=%0h exp acc=fe pc=2", ok, acc, pc);
      end
      mem[0] = 8'h01; mem[1] = 8'h40;
      pulse_run();
      wait_retired(8'd4, 100, cyc, ok);
      total++;
      if (!ok || acc !== 8'hFF || pc !== 4'h1) begin
         bad++;
         $display("FAIL acc_ff got ok=%0b acc=%0h pc=%0h exp acc=ff pc=1", ok, acc, pc);
      end
      wait_retired(8'd6, 100, cyc, ok);
      total++;
      if (!ok || cyc != 4 || acc !== 8'h00 || pc !== 4'h1) begin
         bad++;
         $display("FAIL acc_wrap got ok=%0b cyc=%0d acc=%0h pc=%0h exp cyc=4 acc=00 pc=1", ok, cyc, acc, pc);
      end
      apply_reset();
   endtask

   task automatic test_pc_wrap();
      int  cyc;
      bit  ok;
      apply_reset();
      foreach (mem[i]) mem[i] = 8'h01;
      pulse_run();
      wait_retired(8'd16, 200, cyc, ok);
      total++;
      if (!ok || pc !== 4'h0 || acc !== 8'h10 || imem_req !== 1'b1 || imem_addr !== 4'h0) begin
         bad++;
         $display("FAIL pc_wrap got ok=%0b pc=%0h acc=%0h req=%0b addr=%0h exp pc=0 acc=10 req=1 addr=0", ok, pc, acc, imem_req, imem_addr);
      end
      apply_reset();
   endtask

   task automatic test_reset_mid_fetch();
      int  cyc;
      bit  ok;
      apply_reset();
      foreach (mem[i]) mem[i] = 8'h01;
      pulse_run();
      wait_retired(8'd3, 100, cyc, ok);
      @(posedge clk); #2 ack_delay = 20;
      repeat (3) @(posedge clk);
      #2 run = 1'b1;
      @(negedge clk);
      total++;
      if (imem_req !== 1'b1 || acc === 8'h00) begin
         bad++;
         $display("FAIL pre_reset_wait got req=%0b acc=%0h exp req=1 acc nonzero", imem_req, acc);
      end
      assert_reset();
      #1;
      total++;
      if (imem_req !== 1'b0 || pc !== 4'h0 || acc !== 8'h00 || retired !== 8'h00 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_fetch got req=%0b pc=%0h acc=%0h ret=%0h busy=%0b exp all 0", imem_req, pc, acc, retired, busy);
      end
      release_reset();
      repeat (5) @(posedge clk);
      #2;
      total++;
      if (imem_req !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL run_held_reset got req=%0b busy=%0b exp 0 0", imem_req, busy);
      end
      run = 1'b0;
      ack_delay = 0;
      pulse_run();
      wait_retired(8'd1, 50, cyc, ok);
      @(negedge clk);
      total++;
      if (!ok || pc !== 4'h1 || acc !== 8'h01) begin
         bad++;
         $display("FAIL restart_addr0 got ok=%0b pc=%0h acc=%0h exp pc=1 acc=01", ok, pc, acc);
      end
      apply_reset();
   endtask

   task automatic test_halt_resume();
      int  cyc;
      bit  ok;
      apply_reset();
      foreach (mem[i]) mem[i] = 8'h00;
      mem[0] = 8'h01; mem[1] = 8'hF0; mem[2] = 8'h02; mem[3] = 8'hF0;
      @(posedge clk); #2 run = 1'b1;
      run_until_halted(100, cyc, ok);
      repeat (5) @(posedge clk);
      #2;
      total++;
      if (!ok || halted !== 1'b1 || busy !== 1'b0 || pc !== 4'h2 || acc !== 8'h01) begin
         bad++;
         $display("FAIL run_held_halt got ok=%0b hlt=%0b busy=%0b pc=%0h acc=%0h exp hlt=1 busy=0 pc=2 acc=01", ok, halted, busy, pc, acc);
      end
      run = 1'b0;
      @(posedge clk); #2 run = 1'b1;
      @(posedge clk); #2 run = 1'b0;
      @(posedge clk); #2 run = 1'b1;
      @(posedge clk); #2 run = 1'b0;
      run_until_halted(100, cyc, ok);
      repeat (4) @(posedge clk);
      #2;
      total++;
      if (!ok || halted !== 1'b1 || pc !== 4'h4 || acc !== 8'h03 || retired !== 8'h04) begin
         bad++;
         $display("FAIL resume got ok=%0b hlt=%0b pc=%0h acc=%0h ret=%0h exp hlt=1 pc=4 acc=03 ret=04", ok, halted, pc, acc, retired);
      end
   endtask

   initial begin
      rst_n = 1'b1;
      run   = 1'b0;
      imem_ack  = 1'b0;
      imem_data = 8'h00;
      foreach (mem[i]) mem[i] = 8'h00;
      test_reset();
      test_basic_program();
      test_ack_delay();
      test_acc_wrap_jmp();
      test_pc_wrap();
      test_reset_mid_fetch();
      test_halt_resume();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
